// File: rtl/sdram_line_streamer.sv
// Streams one display line from SDRAM into a pixel FIFO, applying a signed
// H/V pan with either fill or modulo wrap at the frame edges.
module sdram_line_streamer #(
  parameter int              PIX_W    = 8,
  parameter int              WORD_W   = 16,
  parameter int              H_PIXELS = 1024,
  parameter int              V_LINES  = 768,
  parameter int              ADDR_W   = 25,
  parameter int              FRAME_W  = 6,
  parameter int              OFF_W    = 8,
  parameter int              MAX_OUT  = 4,
  parameter logic [PIX_W-1:0] FILL    = '0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLOAD_REQ,
  input  logic [12:0]       iLINE,
  input  logic [FRAME_W-1:0] iFRAME_ID,
  input  logic              iOFFSET_H_SIGN,
  input  logic [OFF_W-1:0]  iOFFSET_H,
  input  logic              iOFFSET_V_SIGN,
  input  logic [OFF_W-1:0]  iOFFSET_V,
  input  logic              iWRAP,
  input  logic              iWAIT_REQUEST,
  output logic              oRD_EN,
  output logic [ADDR_W-1:0] oRD_ADDR,
  input  logic [WORD_W-1:0] iRD_DATA,
  input  logic              iRD_DATAVALID,
  output logic [PIX_W-1:0]  oFIFO_WDATA,
  output logic              oFIFO_WEN,
  input  logic              iFIFO_WFULL,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oOVERRUN
);

  localparam int PPW = WORD_W / PIX_W;
  localparam int WPL = H_PIXELS / PPW;
  localparam int WPF = WPL * V_LINES;
  localparam int CW  = $clog2(H_PIXELS + 1);
  localparam int WCW = $clog2(WPL + 2);
  localparam int WIW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int PSW = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int BCW = $clog2(MAX_OUT + 1);
  localparam int OW  = BCW + 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LEAD, S_FETCH, S_TRAIL, S_DONE} state_t;
  state_t state_q, state_d;

  logic [12:0]        line_q;
  logic [FRAME_W-1:0] frame_q;
  logic               hsgn_q, vsgn_q, wrap_q, overrun_q;
  logic [OFF_W-1:0]   hoff_q, voff_q;

  logic [CW-1:0]      lead_left_q, pix_left_q, trail_left_q;
  logic [WCW-1:0]     rd_left_q;
  logic [WIW-1:0]     rd_word_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [PSW-1:0]     pix_sel_q;
  logic [WORD_W-1:0]  buf_q [MAX_OUT];
  logic [BPW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [BCW-1:0]     count_q, inflight_q;

  int dx, dy, adx, sl, st;
  int su_lead, su_npix, su_trail, su_start, su_nwords;
  logic               all_fill;
  logic [WIW-1:0]     su_word;
  logic [ADDR_W-1:0]  su_addr;

  logic lead_wr, pix_wr, trail_wr, pop, rd_issue, rd_accept;
  logic [OW-1:0]      outstanding;
  logic [PIX_W-1:0]   cur_pix;

  // Line geometry: leading fills, fetched pixel run, trailing fills and the
  // first word to read, all derived once from the latched request.
  always_comb begin
    dx       = hsgn_q ? -int'(hoff_q) : int'(hoff_q);
    dy       = vsgn_q ? -int'(voff_q) : int'(voff_q);
    adx      = (dx < 0) ? -dx : dx;
    sl       = int'(line_q) - dy;
    st       = 0;
    su_lead  = 0;
    su_trail = 0;
    su_npix  = H_PIXELS;
    all_fill = (int'(line_q) >= V_LINES) ||
               (!wrap_q && (sl < 0 || sl >= V_LINES || adx >= H_PIXELS));
    if (all_fill) begin
      su_lead = H_PIXELS;
      su_npix = 0;
      sl      = 0;
    end else if (wrap_q) begin
      sl = ((sl % V_LINES) + V_LINES) % V_LINES;
      st = (((-dx) % H_PIXELS) + H_PIXELS) % H_PIXELS;
    end else if (dx >= 0) begin
      su_lead = dx;
      su_npix = H_PIXELS - dx;
    end else begin
      st       = adx;
      su_npix  = H_PIXELS - adx;
      su_trail = adx;
    end
    su_start  = st % PPW;
    su_nwords = (su_start + su_npix + PPW - 1) / PPW;
    su_word   = WIW'(st / PPW);
    su_addr   = ADDR_W'(frame_q) * ADDR_W'(WPF) + ADDR_W'(sl) * ADDR_W'(WPL) + ADDR_W'(st / PPW);
  end

  assign outstanding = {1'b0, inflight_q} + {1'b0, count_q};
  assign cur_pix     = buf_q[rd_ptr_q][int'(pix_sel_q) * PIX_W +: PIX_W];
  assign rd_issue    = oRD_EN && !iWAIT_REQUEST;
  assign rd_accept   = iRD_DATAVALID && (inflight_q != '0);
  assign pop         = pix_wr && ((pix_sel_q == PSW'(PPW - 1)) || (pix_left_q == CW'(1)));

  always_ff @(posedge iCLK) begin
    if (!iRST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iLOAD_REQ) state_d = S_SETUP;
      S_SETUP: begin
        if (su_lead != 0)       state_d = S_LEAD;
        else if (su_npix != 0)  state_d = S_FETCH;
        else if (su_trail != 0) state_d = S_TRAIL;
        else                    state_d = S_DONE;
      end
      S_LEAD: if (lead_wr && lead_left_q == CW'(1)) begin
        if (pix_left_q != '0)        state_d = S_FETCH;
        else if (trail_left_q != '0) state_d = S_TRAIL;
        else                         state_d = S_DONE;
      end
      S_FETCH: if (pix_wr && pix_left_q == CW'(1))
        state_d = (trail_left_q != '0) ? S_TRAIL : S_DONE;
      S_TRAIL: if (trail_wr && trail_left_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oRD_EN      = 1'b0;
    lead_wr     = 1'b0;
    pix_wr      = 1'b0;
    trail_wr    = 1'b0;
    oFIFO_WDATA = '0;
    case (state_q)
      S_LEAD: begin
        lead_wr = !iFIFO_WFULL;
        if (lead_wr) oFIFO_WDATA = FILL;
      end
      S_FETCH: begin
        oRD_EN = (rd_left_q != '0) && (outstanding < OW'(MAX_OUT));
        pix_wr = (count_q != '0) && !iFIFO_WFULL;
        if (pix_wr) oFIFO_WDATA = cur_pix;
      end
      S_TRAIL: begin
        trail_wr = !iFIFO_WFULL;
        if (trail_wr) oFIFO_WDATA = FILL;
      end
      default: ;
    endcase
    oFIFO_WEN = lead_wr || pix_wr || trail_wr;
    oBUSY     = (state_q != S_IDLE);
    oDONE     = (state_q == S_DONE);
    oOVERRUN  = overrun_q;
  end

  assign oRD_ADDR = rd_addr_q;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      line_q       <= '0;
      frame_q      <= '0;
      hsgn_q       <= 1'b0;
      vsgn_q       <= 1'b0;
      hoff_q       <= '0;
      voff_q       <= '0;
      wrap_q       <= 1'b0;
      overrun_q    <= 1'b0;
      lead_left_q  <= '0;
      pix_left_q   <= '0;
      trail_left_q <= '0;
      rd_left_q    <= '0;
      rd_word_q    <= '0;
      rd_addr_q    <= '0;
      pix_sel_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) buf_q[i] <= '0;
    end else begin
      if (state_q == S_IDLE && iLOAD_REQ) begin
        line_q  <= iLINE;
        frame_q <= iFRAME_ID;
        hsgn_q  <= iOFFSET_H_SIGN;
        hoff_q  <= iOFFSET_H;
        vsgn_q  <= iOFFSET_V_SIGN;
        voff_q  <= iOFFSET_V;
        wrap_q  <= iWRAP;
      end
      if (state_q != S_IDLE && iLOAD_REQ) overrun_q <= 1'b1;

      if (state_q == S_SETUP) begin
        lead_left_q  <= CW'(su_lead);
        pix_left_q   <= CW'(su_npix);
        trail_left_q <= CW'(su_trail);
        rd_left_q    <= WCW'(su_nwords);
        rd_word_q    <= su_word;
        rd_addr_q    <= su_addr;
        pix_sel_q    <= PSW'(su_start);
      end
      if (lead_wr)  lead_left_q  <= lead_left_q - CW'(1);
      if (trail_wr) trail_left_q <= trail_left_q - CW'(1);

      // Circular word walk: stepping past the last word of the line returns
      // to word 0 of the same source line.
      if (rd_issue) begin
        rd_left_q <= rd_left_q - WCW'(1);
        if (rd_word_q == WIW'(WPL - 1)) begin
          rd_word_q <= '0;
          rd_addr_q <= rd_addr_q - ADDR_W'(WPL - 1);
        end else begin
          rd_word_q <= rd_word_q + WIW'(1);
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
      end

      if (pix_wr) begin
        pix_left_q <= pix_left_q - CW'(1);
        pix_sel_q  <= pop ? '0 : pix_sel_q + PSW'(1);
      end

      if (rd_accept) begin
        buf_q[wr_ptr_q] <= iRD_DATA;
        wr_ptr_q        <= (wr_ptr_q == BPW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + BPW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == BPW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + BPW'(1);

      inflight_q <= inflight_q + BCW'(rd_issue) - BCW'(rd_accept);
      count_q    <= count_q + BCW'(rd_accept) - BCW'(pop);
    end
  end

endmodule

// File: doc/sdram_line_streamer.md
SDRAM_LINE_STREAMER -- requirements
Module: sdram_line_streamer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-002 SHALL have parameter WORD_W, default 16, SDRAM data width; PPW = WORD_W/PIX_W pixels per word, integer, power of two.
REQ-003 SHALL have parameter H_PIXELS, default 1024, pixels per line, multiple of PPW.
REQ-004 SHALL have parameter V_LINES, default 768, lines per frame.
REQ-005 SHALL have parameters ADDR_W (25), FRAME_W (6), OFF_W (8), MAX_OUT (4): address width, frame-id width, offset magnitude width, and read words in flight or buffered.
REQ-006 SHALL have parameter FILL, default 0, PIX_W-bit fill pixel value.
REQ-007 SHALL have ports: iCLK in 1, single clock; iRST_N in 1, synchronous active-low reset.
REQ-008 SHALL have ports: iLOAD_REQ in 1, line request pulse; iLINE in 13, output line index.
REQ-009 SHALL have ports: iFRAME_ID in FRAME_W; iOFFSET_H_SIGN in 1 and iOFFSET_H in OFF_W, sign-magnitude, + right; iOFFSET_V_SIGN in 1 and iOFFSET_V in OFF_W, + down; iWRAP in 1, 1 = modulo wrap, 0 = fill.
REQ-010 SHALL have Avalon read ports: iWAIT_REQUEST in 1; oRD_EN out 1; oRD_ADDR out ADDR_W; iRD_DATA in WORD_W; iRD_DATAVALID in 1.
REQ-011 SHALL have FIFO ports: oFIFO_WDATA out PIX_W; oFIFO_WEN out 1; iFIFO_WFULL in 1.
REQ-012 SHALL have status ports: oBUSY out 1; oDONE out 1, one-cycle pulse; oOVERRUN out 1, sticky.

Function
REQ-013 SHALL accept iLOAD_REQ only in IDLE, latching iLINE, iFRAME_ID, both offsets and iWRAP; later input changes have no effect on the line in progress.
REQ-014 SHALL, on iLOAD_REQ while oBUSY=1, ignore the request and set oOVERRUN.
REQ-015 SHALL emit exactly H_PIXELS FIFO writes per accepted request: output pixel x = source pixel (x - dx) on source line (v - dy).
REQ-016 SHALL, with iWRAP=0, use FILL for any source coordinate outside [0,H_PIXELS) or [0,V_LINES); with iWRAP=1, reduce coordinates modulo H_PIXELS and V_LINES.
REQ-017 SHALL treat |dx| >= H_PIXELS in fill mode as all-fill, and iLINE >= V_LINES as an all-fill line in both modes.
REQ-018 SHALL issue zero SDRAM reads for an all-fill line.
REQ-019 SHALL compute word address as frame*(H_PIXELS*V_LINES/PPW) + srcline*(H_PIXELS/PPW) + wordidx, truncated to ADDR_W.
REQ-020 SHALL, in fill mode, use: dx>=0: dx lead fills, then source pixels 0..H-1-dx; dx<0: source pixels |dx|..H-1, then |dx| trail fills.
REQ-021 SHALL, in wrap mode, start at source pixel s = (-dx) mod H and read words circularly, wrapping wordidx from H/PPW-1 to 0.
REQ-022 SHALL read only the words containing needed pixels, in ascending circular order, and discard unused leading/trailing pixels of partial words.
REQ-023 SHALL unpack pixels from each word low bits first (bits PIX_W-1:0 first).
REQ-024 SHALL use states IDLE, SETUP, LEAD, FETCH, TRAIL, DONE: IDLE->SETUP on accept; SETUP->LEAD/FETCH/TRAIL/DONE skipping empty phases; DONE lasts 1 cycle asserting oDONE, then IDLE.
REQ-025 SHALL hold oRD_EN and oRD_ADDR stable while iWAIT_REQUEST=1; a read is issued on the cycle oRD_EN=1 and iWAIT_REQUEST=0.
REQ-026 SHALL assert oRD_EN only while (in-flight + buffered words) < MAX_OUT; the internal word buffer holds MAX_OUT words and never overflows.
REQ-027 SHALL write at most one pixel per cycle, only when iFIFO_WFULL=0, with oFIFO_WDATA valid in the same cycle as oFIFO_WEN.
REQ-028 SHALL keep oBUSY=1 from the cycle after acceptance through the DONE cycle.
REQ-029 SHALL ignore iRD_DATAVALID when the in-flight count is zero.

Reset
REQ-030 SHALL, when iRST_N=0 at a rising edge, enter IDLE and clear oRD_EN, oFIFO_WEN, oBUSY, oDONE, oOVERRUN, counters and the word buffer; oRD_ADDR and oFIFO_WDATA reset to 0.
REQ-031 SHALL abort a line in progress on reset without a further FIFO write or oDONE.

Verification (PIX_W=8, WORD_W=16, H=16, V=8, MAX_OUT=4; frame 2 base 128, line stride 8)
REQ-032 Frame 2, line 3, no offsets -> 8 reads at addresses 152..159; 16 writes in order low byte then high byte of each word; oDONE pulses once.
REQ-033 Fill mode, dx=+3, line 3 -> 3 writes of FILL, then source pixels 0..12; 7 reads at 152..158.
REQ-034 Wrap mode, dx=-3 -> reads at 153..159, then 152, 153; output is source pixels 3..15 then 0..2.
REQ-035 Fill mode, line 1, dy=+5 -> 16 FILL writes, zero reads; iWRAP=1 with the same request -> reads source line 4 (addresses 160..167).
REQ-036 iWAIT_REQUEST held 5 cycles with iFIFO_WFULL toggling -> oRD_ADDR stable, no write while full, never more than 4 words in flight plus buffered, all 16 pixels correct.
REQ-037 Second iLOAD_REQ during FETCH -> ignored and oOVERRUN=1; iRST_N=0 mid-FETCH -> IDLE next cycle, outputs 0, no oDONE.
